uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin scheduler that shares the single UART transmit path of `uart_io` between four hardware-thread requesters. Each requester presents bytes on a valid/ready handshake. The arbiter grants one requester at a time and holds (locks) the grant until a line terminator, a burst limit or an idle timeout, so printed lines never interleave. It sits between the per-thread print queues and the gateway's TX byte input.

## Interface
- `NUM_REQ`, 4: number of requesters. Fixed at 4, matching the 2-bit thread ID.
- `MAX_BURST`, 64: maximum bytes sent per grant before a forced release.
- `IDLE_TIMEOUT`, 16: consecutive cycles the granted requester may hold `req_valid` low before a forced release.
- `EOL_CHAR`, 8'h0A: byte value that releases the grant once it is accepted.

Ports:
- `clk`, input, 1: single clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, NUM_REQ: per-requester byte valid.
- `req_data`, input, NUM_REQ x 8: per-requester byte, packed as `[NUM_REQ-1:0][7:0]`.
- `req_ready`, output, NUM_REQ: per-requester accept. Acts as a one-hot subset of the grant.
- `tx_valid`, output, 1: byte valid toward the UART TX side.
- `tx_data`, output, 8: byte toward the UART TX side.
- `tx_ready`, input, 1: UART TX side accepts the byte.
- `grant_id`, output, 2: current or last granted requester.
- `busy`, output, 1: high while in LOCK or while `tx_valid` is high.

## Operation
- FSM has two states, IDLE and LOCK. Reset state is IDLE.
- **IDLE:**
  - `req_ready` = 0.
  - If any `req_valid` is high, pick the first set bit searching upward from `(rr_ptr+1) mod 4`.
  - Register the pick into `grant_id`, clear `burst_cnt` and `idle_cnt`, and go to LOCK.
- **LOCK:**
  - `req_ready[grant_id] = ~tx_valid | tx_ready`. All other `req_ready` bits are 0.
  - An accept is `req_valid[g] & req_ready[g]`. On accept:
    - `tx_data` <= `req_data[g]` and `tx_valid` <= 1.
    - `burst_cnt` increments and `idle_cnt` clears.
- **Release**, evaluated each LOCK cycle; the first matching condition applies:
  - accepted byte == EOL_CHAR;
  - accept with `burst_cnt == MAX_BURST-1`;
  - `idle_cnt == IDLE_TIMEOUT-1` with `req_valid[g]` low.
- On release, the next state is IDLE and `rr_ptr` <= `grant_id`.
- `idle_cnt` increments in LOCK on every cycle with `req_valid[g]` low. It saturates and never wraps.
- **Output register:**
  - When `tx_valid & tx_ready` with no new accept, `tx_valid` <= 0.
  - `tx_data` is held stable while `tx_valid & ~tx_ready`.
- Widths:
  - `burst_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `idle_cnt` is `$clog2(IDLE_TIMEOUT+1)` bits.
  - `rr_ptr` is 2 bits and wraps 3→0.

## Timing
- Reset values of all outputs are 0: `req_ready`, `tx_valid`, `tx_data`, `grant_id`, `busy`. `rr_ptr` resets to 3, so requester 0 has first priority.
- Arbitration latency: `req_valid` rising in IDLE at cycle N → LOCK and `req_ready` high at N+1.
- Datapath latency: accept at cycle N → `tx_valid`/`tx_data` at N+1.
- Throughput: 1 byte/cycle while `tx_ready` stays high.
- Release to re-grant: at least 1 IDLE cycle. After releasing g, the next pick starts at g+1, even if g is still requesting.
- A byte accepted in the release cycle is still delivered. `busy` stays high until it leaves.
- Back-pressure: with `tx_ready` low, `req_ready` drops in the same cycle (combinational). No byte is lost or duplicated.
- Granted requester drops `req_valid` and the output byte is still stalled: `idle_cnt` still counts.
- Reset asserted mid-operation: FSM returns to IDLE and any held `tx_data` byte is discarded.

## Structure
- Add to `lotr_pkg`:
  - `t_uart_arb_state` enum {IDLE, LOCK};
  - `UART_ARB_NUM_REQ = 4`;
  - `UART_EOL_CHAR = 8'h0A`.
- One sub-module, `rr_pick4`: combinational rotate-priority picker. Inputs are `req[3:0]` and `ptr[1:0]`; outputs are `gnt_id[1:0]` and `any`.
- FSM, counters and output register live in `uart_tx_arb`.

## Test plan
- Single requester: req 2 sends "Hi\n" with `tx_ready` = 1 → `tx_data` 0x48, 0x69, 0x0A on consecutive cycles starting 2 cycles after `req_valid`; `grant_id` = 2; returns to IDLE after 0x0A.
- All four request simultaneously out of reset, each sending one "X\n" line → grant order 0, 1, 2, 3. Lines are never interleaved.
- Req 1 streams 100 bytes with no 0x0A, `MAX_BURST` = 64 → release after the 64th byte. Req 1 is re-granted only after other pending requesters, and its remaining 36 bytes arrive intact.
- Granted req 0 drops valid for 16 cycles while req 3 is pending → release on the 16th idle cycle; req 3 is granted 2 cycles later.
- `tx_ready` held low for 10 cycles mid-line → `tx_data` stable, `req_ready` low, no bytes dropped or repeated.
- `rstn` pulsed low while in LOCK with `tx_valid` = 1 → all outputs 0 immediately (async), FSM in IDLE, requester 0 has priority afterwards.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared types and constants for the lotr platform blocks.
package lotr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } t_uart_arb_state;

    localparam int         UART_ARB_NUM_REQ = 4;
    localparam logic [7:0] UART_EOL_CHAR    = 8'h0A;

endpackage

// File: rtl/uart_tx_arb_rr_pick4.sv
// Rotate-priority picker: first set request searching upward from ptr+1, wrapping 3->0.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_id,
    output logic       any
);

    // Walk from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt_id = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(int'(ptr) + i)]) begin
                gnt_id = 2'(int'(ptr) + i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, line-locking scheduler sharing one UART TX byte path among four requesters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant held; picks the next requester after rr_ptr
// LOCK  | grant_id owns the TX path until EOL, burst limit or idle timeout
module uart_tx_arb
    import lotr_pkg::*;
#(
    parameter int         NUM_REQ      = UART_ARB_NUM_REQ,
    parameter int         MAX_BURST    = 64,
    parameter int         IDLE_TIMEOUT = 16,
    parameter logic [7:0] EOL_CHAR     = UART_EOL_CHAR
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [1:0]              grant_id,
    output logic                    busy
);

    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam int            IW         = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);

    t_uart_arb_state state_q, state_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [1:0] pick_id;
    logic       pick_any;
    logic       g_valid;
    logic [7:0] g_data;
    logic       g_ready;
    logic       accept;
    logic       rel;

    rr_pick4 u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign g_valid = req_valid[grant_id_q];
    assign g_data  = req_data[grant_id_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            grant_id_q  <= 2'd0;
            rr_ptr_q    <= 2'd3;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        rel         = 1'b0;

        // The output register drains independently of state, so a byte taken
        // in the release cycle still leaves while the FSM sits in IDLE.
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = g_data;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = LOCK;
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            LOCK: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    idle_cnt_d  = '0;
                end else if (!g_valid && idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end

                if (accept && g_data == EOL_CHAR) begin
                    rel = 1'b1;
                end else if (accept && burst_cnt_q == BURST_LAST) begin
                    rel = 1'b1;
                end else if (!g_valid && idle_cnt_q == IDLE_LAST) begin
                    rel = 1'b1;
                end

                if (rel) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        g_ready   = 1'b0;
        if (state_q == LOCK) begin
            g_ready               = ~tx_valid_q | tx_ready;
            req_ready[grant_id_q] = g_ready;
        end
        accept = g_valid & g_ready;
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == LOCK) | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus random line traffic
// compared against a segment-level round-robin model of the expected byte stream.
module tb_uart_tx_arb;

    localparam logic [7:0] EOL = 8'h0A;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    uart_tx_arb dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] src [4][$];
    logic [7:0] exp_b[$];
    int         exp_g[$];
    bit         exp_last[$];
    int         out_cyc[$];
    int         out_n = 0;
    int         rdy_first[4];
    logic [3:0] acc_q = 4'h0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         txr_pct = 100;
    int         stall_lo = -1;
    int         stall_hi = -1;
    int         t0 = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples at the falling edge, where inputs and state are settled.
    always @(negedge clk) begin
        acc_q = req_valid & req_ready;
        if (rstn) begin
            for (int r = 0; r < 4; r++) begin
                if (req_ready[r] && rdy_first[r] < 0) rdy_first[r] = cyc;
            end
            check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (tx_valid || req_ready != 4'h0) check_eq("busy_high", 32'(busy), 32'd1);
            if (tx_valid && !tx_ready) check_eq("bp_ready_low", 32'(req_ready), 32'd0);
            if (prev_stall) begin
                check_eq("hold_valid", 32'(tx_valid), 32'd1);
                check_eq("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (out_n < exp_b.size()) begin
                    check_eq("tx_data", 32'(tx_data), 32'(exp_b[out_n]));
                    if (!exp_last[out_n]) check_eq("grant_id", 32'(grant_id), 32'(exp_g[out_n]));
                end else begin
                    check_eq("extra_byte", 32'(out_n), 32'(exp_b.size()));
                end
                out_cyc.push_back(cyc);
                out_n++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            if (src[r].size() > 0) begin
                req_valid[r] = 1'b1;
                req_data[r]  = src[r][0];
            end else begin
                req_valid[r] = 1'b0;
                req_data[r]  = 8'h00;
            end
        end
        if (cyc >= stall_lo && cyc <= stall_hi) tx_ready = 1'b0;
        else tx_ready = ($urandom_range(0, 99) < txr_pct);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            if (acc_q[r] && src[r].size() > 0) src[r].delete(0);
        end
        drive();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int r = 0; r < 4; r++) src[r].delete();
        exp_b.delete();
        exp_g.delete();
        exp_last.delete();
        out_cyc.delete();
        out_n     = 0;
        rdy_first = '{-1, -1, -1, -1};
        stall_lo  = -1;
        stall_hi  = -1;
        txr_pct   = 100;
        drive();
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Reference: with all data queued up front and never paused, each grant is a
    // segment ending at EOL, at 64 bytes, or when that requester runs dry; grants
    // rotate to the first non-empty requester after the previous one, starting after 3.
    task automatic build_expected();
        logic [7:0] q [4][$];
        int ptr;
        int r;
        int n;
        logic [7:0] b;
        bit last;
        for (int k = 0; k < 4; k++) q[k] = src[k];
        ptr = 3;
        forever begin
            r = -1;
            for (int k = 4; k >= 1; k--) begin
                if (q[(ptr + k) % 4].size() > 0) r = (ptr + k) % 4;
            end
            if (r < 0) break;
            n = 0;
            last = 1'b0;
            while (!last) begin
                b = q[r].pop_front();
                n++;
                last = (b == EOL) || (n == 64) || (q[r].size() == 0);
                exp_b.push_back(b);
                exp_g.push_back(r);
                exp_last.push_back(last);
            end
            ptr = r;
        end
    endtask

    task automatic start();
        build_expected();
        t0 = cyc;
        drive();
    endtask

    task automatic run(input int budget, input string tag);
        int n = 0;
        int left;
        while (!(out_n == exp_b.size() && !busy) && n < budget) begin
            tick();
            n++;
        end
        left = src[0].size() + src[1].size() + src[2].size() + src[3].size();
        check_eq({tag, "_drained"}, 32'(out_n), 32'(exp_b.size()));
        check_eq({tag, "_src_left"}, 32'(left), 32'd0);
    endtask

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) src[r].push_back(s[i]);
    endtask

    initial begin
        int nl;
        int len;

        do_reset();
        push_str(2, "Hi");
        src[2].push_back(EOL);
        start();
        run(200, "hi");
        check_eq("hi_first_lat", 32'(out_cyc[0] - t0), 32'd2);
        check_eq("hi_last_lat", 32'(out_cyc[2] - t0), 32'd4);
        check_eq("hi_idle_cyc", 32'(cyc - t0), 32'd5);
        check_eq("hi_grant_kept", 32'(grant_id), 32'd2);

        do_reset();
        for (int r = 0; r < 4; r++) begin
            src[r].push_back("X");
            src[r].push_back(EOL);
        end
        start();
        run(200, "all4");
        check_eq("all4_arb_lat", 32'(rdy_first[0] - t0), 32'd1);

        do_reset();
        for (int i = 0; i < 100; i++) src[1].push_back(8'(8'h30 + (i % 40)));
        push_str(0, "C");
        src[0].push_back(EOL);
        push_str(2, "AB");
        src[2].push_back(EOL);
        start();
        run(2000, "burst");

        do_reset();
        push_str(0, "ab");
        push_str(3, "Z");
        src[3].push_back(EOL);
        start();
        run(500, "idle");
        check_eq("idle_grant0_lat", 32'(rdy_first[0] - t0), 32'd1);
        check_eq("idle_regrant3", 32'(rdy_first[3] - t0), 32'd20);

        do_reset();
        push_str(1, "abcdef");
        src[1].push_back(EOL);
        build_expected();
        t0 = cyc;
        stall_lo = t0 + 4;
        stall_hi = t0 + 13;
        drive();
        run(500, "stall");
        check_eq("stall_c_out", 32'(out_cyc[2] - t0), 32'd14);
        check_eq("stall_d_out", 32'(out_cyc[3] - t0), 32'd15);

        do_reset();
        push_str(2, "hello");
        src[2].push_back(EOL);
        start();
        tick();
        tick();
        tick();
        check_eq("mid_tx_valid_pre", 32'(tx_valid), 32'd1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        do_reset();
        push_str(3, "Q");
        src[3].push_back(EOL);
        push_str(0, "R");
        src[0].push_back(EOL);
        start();
        run(200, "post_rst");
        check_eq("post_rst_prio0", 32'(rdy_first[0] - t0), 32'd1);

        for (int it = 0; it < 4; it++) begin
            do_reset();
            txr_pct = $urandom_range(40, 100);
            for (int r = 0; r < 4; r++) begin
                nl = $urandom_range(0, 3);
                for (int l = 0; l < nl; l++) begin
                    len = $urandom_range(1, 90);
                    for (int j = 0; j < len - 1; j++) src[r].push_back(8'($urandom_range(32, 126)));
                    src[r].push_back(EOL);
                end
            end
            start();
            run(20000, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
